fir_tap_arbiter: RTL

//  Shares the single-port tap coefficient BRAM between two requesters:
//  - AXI-Lite host: coefficient read/write.
//  - FIR engine: coefficient fetch during filtering.

---
 rtl/fir_tap_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fir_tap_arbiter.sv
// rtl/fir_tap_arbiter.sv - shares the tap coefficient BRAM between the AXI-Lite host and the FIR engine
// Engine has priority while ap_busy=1; a bounded-wait counter forces a host slot so host reads never starve.
module fir_tap_arbiter #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int MAX_WAIT    = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   ap_busy,
    input  logic                   h_req,
    input  logic                   h_we,
    input  logic [pADDR_WIDTH-1:0] h_addr,
    input  logic [pDATA_WIDTH-1:0] h_wdata,
    output logic                   h_gnt,
    output logic                   h_err,
    output logic                   h_rvalid,
    output logic [pDATA_WIDTH-1:0] h_rdata,
    input  logic                   e_req,
    input  logic [pADDR_WIDTH-1:0] e_addr,
    output logic                   e_gnt,
    output logic                   e_rvalid,
    output logic [pDATA_WIDTH-1:0] e_rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [pADDR_WIDTH-1:0] LAST_ADDR = pADDR_WIDTH'(4 * Tape_Num - 4);
    localparam logic [CW-1:0] FORCE_AT = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_HOSTPRI = 2'd0,
        S_ENGPRI  = 2'd1,
        S_FORCE   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   wait_cnt_next;
    logic            h_legal;
    logic            h_access;
    logic            h_stall;
    logic            h_rd_q;
    logic            e_rd_q;
    logic            h_err_q;

    // Illegal requests are still granted so the host sees them consumed, but never reach the BRAM.
    assign h_legal  = (h_addr[1:0] == 2'b00) && (h_addr <= LAST_ADDR) && !(h_we && ap_busy);
    assign h_access = h_gnt && h_legal;
    assign h_stall  = h_req && !h_gnt;

    always_comb begin
        h_gnt = 1'b0;
        e_gnt = 1'b0;
        if (!axis_rst) begin
            case (state)
                S_HOSTPRI: begin
                    h_gnt = h_req;
                    e_gnt = e_req && !h_req;
                end
                S_ENGPRI: begin
                    e_gnt = e_req;
                    h_gnt = h_req && !e_req;
                end
                S_FORCE: begin
                    h_gnt = h_req;
                end
                default: begin
                    h_gnt = 1'b0;
                    e_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        case (state)
            S_HOSTPRI: begin
                if (ap_busy) state_next = S_ENGPRI;
            end
            S_ENGPRI: begin
                if (h_stall)
                    wait_cnt_next = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CW'(1);
                if (!ap_busy)
                    state_next = S_HOSTPRI;
                else if (h_stall && (wait_cnt_next >= FORCE_AT))
                    state_next = S_FORCE;
            end
            S_FORCE: begin
                state_next = ap_busy ? S_ENGPRI : S_HOSTPRI;
            end
            default: begin
                state_next = S_HOSTPRI;
            end
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state    <= S_HOSTPRI;
            wait_cnt <= '0;
            h_rd_q   <= 1'b0;
            e_rd_q   <= 1'b0;
            h_err_q  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            h_rd_q   <= h_access && !h_we;
            e_rd_q   <= e_gnt;
            h_err_q  <= h_gnt && !h_legal;
        end
    end

    assign tap_EN = h_access || e_gnt;
    assign tap_WE = (h_access && h_we) ? 4'b1111 : 4'b0000;
    assign tap_Di = (h_access && h_we) ? h_wdata : '0;
    assign tap_A  = h_access ? h_addr : (e_gnt ? e_addr : '0);

    // Gating with reset drops a read whose data would land during the reset cycle.
    assign h_rvalid = h_rd_q && !axis_rst;
    assign e_rvalid = e_rd_q && !axis_rst;
    assign h_err    = h_err_q && !axis_rst;
    assign h_rdata  = h_rvalid ? tap_Do : '0;
    assign e_rdata  = e_rvalid ? tap_Do : '0;

endmodule
